debug_sba_obi_guard: RTL and testbench

//  Sits between the debug subsystem's system-bus master port and the system OBI crossbar.

---
 rtl/obi_pkg.sv | 20 ++
 rtl/debug_sba_obi_guard.sv | 158 +++++++++++++++
 tb/tb_debug_sba_obi_guard.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/obi_pkg.sv
// OBI request/response bundles shared by the debug bus guard and the crossbar.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/debug_sba_obi_guard.sv
// Guard between the debug module's system-bus master and the OBI crossbar: window check + response timeout.
// Latency: in-window rvalid one cycle after bus rvalid; out-of-window rvalid+err the cycle after gnt.
// Backpressure: one outstanding txn; dm gnt only while idle; bus req held until bus gnt.
//
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   debug_master_req_i   request from the debug module master
//   debug_master_resp_o  gnt (combinational in IDLE) / registered rvalid + rdata to the debug module
//   debug_master_err_o   error qualifier, valid with debug_master_resp_o.rvalid
//   bus_req_o            request towards the system crossbar
//   bus_resp_i           gnt / rvalid / rdata from the system crossbar
//   timeout_o            one-cycle pulse when the response timeout fires
module debug_sba_obi_guard
    import obi_pkg::*;
#(
    parameter logic [31:0] AddrStart     = 32'h0000_0000,
    parameter logic [31:0] AddrEnd       = 32'hFFFF_FFFF,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  obi_req_t  debug_master_req_i,
    output obi_resp_t debug_master_resp_o,
    output logic      debug_master_err_o,
    output obi_req_t  bus_req_o,
    input  obi_resp_t bus_resp_i,
    output logic      timeout_o
);

    localparam int unsigned     CntW     = $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] CntLast  = CntW'(TimeoutCycles - 1);
    localparam logic [CntW-1:0] CntMax   = '1;
    localparam logic [31:0]     ErrRdata = 32'h0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_DONE,
        S_ERR
    } state_e;

    state_e          r_state;
    logic            r_stale;     // a timed-out txn still owes us a response
    logic [CntW-1:0] r_cnt;
    logic            r_bus_req;
    logic            r_we;
    logic [3:0]      r_be;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic            r_rvalid;
    logic            r_err;
    logic [31:0]     r_rdata;

    logic [32:0]     w_off;
    logic            w_in_win;
    logic            w_usable_rv;
    logic            w_timeout;

    // Window test as a single unsigned offset compare; an address below
    // AddrStart borrows into bit 32 and therefore lands outside the span.
    assign w_off    = {1'b0, debug_master_req_i.addr} - {1'b0, AddrStart};
    assign w_in_win = (w_off <= {1'b0, AddrEnd - AddrStart});

    assign w_usable_rv = (r_state == S_RESP) && bus_resp_i.rvalid && !r_stale;
    // A usable rvalid in the last counted cycle beats the timeout.
    assign w_timeout   = (r_state == S_RESP) && (r_cnt == CntLast) && !w_usable_rv;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_stale   <= 1'b0;
            r_cnt     <= '0;
            r_bus_req <= 1'b0;
            r_we      <= 1'b0;
            r_be      <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rvalid  <= 1'b0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;

            // The owed response may turn up in any state; it is consumed and dropped.
            // A timeout in the same cycle re-arms the flag below (later assignment wins).
            if (bus_resp_i.rvalid && r_stale) begin
                r_stale <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (debug_master_req_i.req) begin
                        r_we    <= debug_master_req_i.we;
                        r_be    <= debug_master_req_i.be;
                        r_addr  <= debug_master_req_i.addr;
                        r_wdata <= debug_master_req_i.wdata;
                        if (w_in_win) begin
                            r_state   <= S_REQ;
                            r_bus_req <= 1'b1;
                        end else begin
                            r_state  <= S_ERR;
                            r_rvalid <= 1'b1;
                            r_err    <= 1'b1;
                            r_rdata  <= ErrRdata;
                        end
                    end
                end
                // No timeout while waiting for gnt: OBI forbids retracting req.
                S_REQ: begin
                    if (bus_resp_i.gnt) begin
                        r_state   <= S_RESP;
                        r_bus_req <= 1'b0;
                        r_cnt     <= '0;
                    end
                end
                S_RESP: begin
                    if (r_cnt != CntMax) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (w_usable_rv) begin
                        r_state  <= S_DONE;
                        r_rvalid <= 1'b1;
                        r_rdata  <= bus_resp_i.rdata;
                    end else if (w_timeout) begin
                        r_state  <= S_ERR;
                        r_stale  <= 1'b1;
                        r_rvalid <= 1'b1;
                        r_err    <= 1'b1;
                        r_rdata  <= ErrRdata;
                    end
                end
                S_DONE, S_ERR: begin
                    r_state <= S_IDLE;
                    r_rdata <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign debug_master_resp_o.gnt    = (r_state == S_IDLE) && debug_master_req_i.req;
    assign debug_master_resp_o.rvalid = r_rvalid;
    assign debug_master_resp_o.rdata  = r_rdata;
    assign debug_master_err_o         = r_err;

    assign bus_req_o.req   = r_bus_req;
    assign bus_req_o.we    = r_we;
    assign bus_req_o.be    = r_be;
    assign bus_req_o.addr  = r_addr;
    assign bus_req_o.wdata = r_wdata;

    assign timeout_o = w_timeout;

endmodule

// File: tb/tb_debug_sba_obi_guard.sv
// Directed + randomized bench for debug_sba_obi_guard against a transaction-level model.
// Latency: n/a.
// Backpressure: bus gnt delay and rvalid delay are randomized per transaction.
module tb_debug_sba_obi_guard;
    import obi_pkg::*;

    localparam logic [31:0] WinLo = 32'h0000_0100;
    localparam logic [31:0] WinHi = 32'h0FFF_FFFF;
    localparam int          T     = 8;

    logic      clk = 1'b0;
    logic      rst_n;
    obi_req_t  dm_req;
    obi_resp_t dm_resp;
    logic      dm_err;
    obi_req_t  bus_req;
    obi_resp_t bus_resp;
    logic      tmo;

    int total = 0;
    int bad   = 0;
    // Model: a timed-out transaction whose late response has not been seen yet.
    bit stale_owed = 1'b0;

    always #5 clk = ~clk;

    debug_sba_obi_guard #(
        .AddrStart     (WinLo),
        .AddrEnd       (WinHi),
        .TimeoutCycles (T)
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .debug_master_req_i  (dm_req),
        .debug_master_resp_o (dm_resp),
        .debug_master_err_o  (dm_err),
        .bus_req_o           (bus_req),
        .bus_resp_i          (bus_resp),
        .timeout_o           (tmo)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic bit in_window(input logic [31:0] a);
        return (a >= WinLo) && (a <= WinHi);
    endfunction

    // One complete dm transaction; resp_at >= T means the bus never answers in time.
    task automatic run_txn(input logic [31:0] addr, input logic we, input logic [3:0] be,
                           input logic [31:0] wdata, input int gnt_wait, input int resp_at,
                           input logic [31:0] rdata, input bit junk_first);
        bit          win = in_window(addr);
        bit          expect_err = 1'b1;
        dm_req.req   = 1'b1;
        dm_req.we    = we;
        dm_req.be    = be;
        dm_req.addr  = addr;
        dm_req.wdata = wdata;
        bus_resp     = '0;
        settle();
        chk("gnt_c0", dm_resp.gnt, 1);
        chk("busreq_c0", bus_req.req, 0);
        chk("rvalid_c0", dm_resp.rvalid, 0);
        tick();
        dm_req = '0;
        if (!win) begin
            dm_req.req  = 1'b1;
            dm_req.addr = $urandom;
            settle();
            chk("oow_rvalid", dm_resp.rvalid, 1);
            chk("oow_err", dm_err, 1);
            chk("oow_rdata", dm_resp.rdata, 0);
            chk("oow_busreq", bus_req.req, 0);
            chk("oow_gnt_held", dm_resp.gnt, 0);
        end else begin
            for (int k = 0; k <= gnt_wait; k++) begin
                bus_resp.gnt = (k == gnt_wait);
                settle();
                chk("req_held", bus_req.req, 1);
                chk("req_addr", bus_req.addr, addr);
                chk("req_we_be", {27'b0, bus_req.we, bus_req.be}, {27'b0, we, be});
                chk("req_wdata", bus_req.wdata, wdata);
                chk("req_no_rvalid", dm_resp.rvalid, 0);
                chk("req_no_tmo", tmo, 0);
                tick();
            end
            bus_resp = '0;
            for (int j = 0; j < T; j++) begin
                bus_resp = '0;
                if (junk_first && j == 0) begin
                    bus_resp.rvalid = 1'b1;
                    bus_resp.rdata  = 32'h0000_1111;
                end else if (j == resp_at) begin
                    bus_resp.rvalid = 1'b1;
                    bus_resp.rdata  = rdata;
                end
                settle();
                chk("resp_no_rvalid", dm_resp.rvalid, 0);
                chk("resp_busreq_low", bus_req.req, 0);
                chk("timeout_pulse", tmo, (j == T - 1) && (resp_at != j));
                if (junk_first && j == 0) stale_owed = 1'b0;
                if (j == resp_at) begin
                    expect_err = 1'b0;
                    tick();
                    break;
                end
                tick();
            end
            if (expect_err) stale_owed = 1'b1;
            bus_resp    = '0;
            dm_req.req  = 1'b1;
            dm_req.addr = $urandom;
            settle();
            chk("dm_rvalid", dm_resp.rvalid, 1);
            chk("dm_err", dm_err, expect_err);
            chk("dm_rdata", dm_resp.rdata, expect_err ? 32'h0 : rdata);
            chk("dm_tmo_low", tmo, 0);
            chk("dm_gnt_held", dm_resp.gnt, 0);
        end
        tick();
        dm_req   = '0;
        bus_resp = '0;
    endtask

    // Deliver the owed late response while the guard is idle; it must vanish.
    task automatic late_in_idle();
        bus_resp.rvalid = 1'b1;
        bus_resp.rdata  = $urandom;
        settle();
        chk("late_dropped", dm_resp.rvalid, 0);
        chk("late_no_busreq", bus_req.req, 0);
        stale_owed = 1'b0;
        tick();
        bus_resp = '0;
        settle();
        chk("late_after", dm_resp.rvalid, 0);
    endtask

    initial begin
        logic [31:0] a;
        int          ra;
        bit          jf;

        rst_n    = 1'b0;
        dm_req   = '0;
        bus_resp = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", dm_resp.gnt, 0);
        chk("rst_rvalid", dm_resp.rvalid, 0);
        chk("rst_rdata", dm_resp.rdata, 0);
        chk("rst_err", dm_err, 0);
        chk("rst_busreq", bus_req.req, 0);
        chk("rst_busaddr", bus_req.addr, 0);
        chk("rst_tmo", tmo, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Read, bus gnt at c2, rvalid at c3 -> dm rvalid at c4.
        run_txn(32'h0000_1000, 1'b0, 4'hF, 32'h0, 1, 0, 32'hCAFE_F00D, 1'b0);
        // Out-of-window write.
        run_txn(32'h2000_0000, 1'b1, 4'hF, 32'hDEAD_BEEF, 0, 0, 32'h0, 1'b0);
        // Window edges.
        run_txn(WinLo - 1, 1'b0, 4'hF, 32'h0, 0, 0, 32'h0, 1'b0);
        run_txn(WinLo, 1'b1, 4'h1, 32'h1234_5678, 0, 0, 32'hA5A5_0001, 1'b0);
        run_txn(WinHi, 1'b0, 4'hC, 32'h0, 2, 3, 32'hA5A5_0002, 1'b0);
        run_txn(WinHi + 1, 1'b0, 4'hF, 32'h0, 0, 0, 32'h0, 1'b0);
        // Timeout, then stale 0x1111 followed by the real 0x2222.
        run_txn(32'h0000_2000, 1'b0, 4'hF, 32'h0, 0, 99, 32'h0, 1'b0);
        run_txn(32'h0000_3000, 1'b0, 4'hF, 32'h0, 0, 1, 32'h0000_2222, 1'b1);
        // rvalid in the last counted cycle wins over the timeout.
        run_txn(32'h0000_4000, 1'b0, 4'hF, 32'h0, 0, T - 1, 32'h7777_8888, 1'b0);
        // Timeout exactly one cycle later, late response swallowed in IDLE.
        run_txn(32'h0000_5000, 1'b0, 4'hF, 32'h0, 0, T, 32'h0, 1'b0);
        late_in_idle();
        // Bus gnt withheld for 5000 cycles.
        run_txn(32'h0400_0000, 1'b1, 4'h3, 32'h5555_AAAA, 5000, 2, 32'h0BAD_CAFE, 1'b0);

        // Reset while in RESP.
        dm_req.req  = 1'b1;
        dm_req.addr = 32'h0000_6000;
        settle();
        tick();
        dm_req       = '0;
        bus_resp.gnt = 1'b1;
        tick();
        bus_resp = '0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busreq", bus_req.req, 0);
        chk("midrst_busaddr", bus_req.addr, 0);
        chk("midrst_rvalid", dm_resp.rvalid, 0);
        chk("midrst_err", dm_err, 0);
        chk("midrst_tmo", tmo, 0);
        stale_owed = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_txn(32'h0000_7000, 1'b0, 4'hF, 32'h0, 1, 1, 32'h600D_0001, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 5))
                0:       a = $urandom;
                1:       a = ($urandom_range(0, 1) != 0) ? WinLo : WinLo - 1;
                2:       a = ($urandom_range(0, 1) != 0) ? WinHi : WinHi + 1;
                default: a = $urandom_range(WinHi, WinLo);
            endcase
            jf = 1'b0;
            if (stale_owed) begin
                if (in_window(a) && $urandom_range(0, 1) != 0) jf = 1'b1;
                else late_in_idle();
            end
            ra = jf ? $urandom_range(1, T + 1) : $urandom_range(0, T + 1);
            run_txn(a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                    $urandom_range(0, 3), ra, $urandom, jf);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
